hazard_ctrl: RTL and testbench

Pipeline control unit for the 5-stage RISC-V core. It drives the stall/flush enables of the F/D, D/E, E/M and M/W pipe registers and the forwarding mux selects in Execute. It also sequences data-memory accesses through a request/ready handshake with a timeout. Sits beside the datapath and observes register addresses and control bits from D, E, M and W.

---
 rtl/hazard_pkg.sv | 25 ++
 rtl/hazard_ctrl_forward_sel.sv | 37 +++
 rtl/hazard_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_pkg
//  Description : Shared types and encodings for the pipeline hazard unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Data-memory access sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FAULT = 2'd2
    } mem_state_t;

    // result_srcE encoding for an instruction whose result comes from a load
    localparam logic [1:0] RESULT_SRC_MEM = 2'b01;

    // Execute-stage forwarding mux selects
    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_forward_sel.sv
`default_nettype none
// ============================================================================
//  Module      : forward_sel
//  Description : Forwarding select for one Execute-stage source operand.
//                The Memory-stage result is younger, so it wins over Writeback.
//  Revision    : 1.0 - initial release
// ============================================================================
module forward_sel
    import hazard_pkg::*;
(
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       reg_writeM,
    input  logic       reg_writeW,
    output logic [1:0] fwd
);

    logic w_hitM;
    logic w_hitW;

    // x0 is hardwired to zero, so a write to it never produces a forward
    assign w_hitM = reg_writeM && (rdM != 5'd0) && (rdM == rsE);
    assign w_hitW = reg_writeW && (rdW != 5'd0) && (rdW == rsE);

    // Priority select: M result, then W result, then register file
    always_comb begin
        fwd = FWD_RF;
        if (w_hitM) begin
            fwd = FWD_M;
        end else if (w_hitW) begin
            fwd = FWD_W;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Stall/flush/forward control for the 5-stage core, plus the
//                data-memory request sequencer with timeout and saturating
//                stall/flush performance counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             reg_writeM,
    input  logic             reg_writeW,
    input  logic [1:0]       result_srcE,
    input  logic             pc_srcE,
    input  logic             mem_reqM,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             mem_fault,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    // Wait counter must be able to hold the value TIMEOUT itself
    localparam int                  c_WAIT_W      = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT_CNT = c_WAIT_W'(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_CNT_ONE     = c_WAIT_W'(1);

    mem_state_t          r_state;
    mem_state_t          w_stateNext;
    logic [c_WAIT_W-1:0] r_waitCnt;
    logic [c_WAIT_W-1:0] w_waitCntNext;
    logic                w_memStall;
    logic                w_memReq;
    logic                w_lwStall;
    logic [CNT_W-1:0]    r_stallCycles;
    logic [CNT_W-1:0]    r_flushCycles;

    forward_sel u_fwdA (
        .rsE        (rs1E),
        .rdM        (rdM),
        .rdW        (rdW),
        .reg_writeM (reg_writeM),
        .reg_writeW (reg_writeW),
        .fwd        (forwardAE)
    );

    forward_sel u_fwdB (
        .rsE        (rs2E),
        .rdM        (rdM),
        .rdW        (rdW),
        .reg_writeM (reg_writeM),
        .reg_writeW (reg_writeW),
        .fwd        (forwardBE)
    );

    // A load in E whose destination is read by the instruction in D
    assign w_lwStall = (result_srcE == RESULT_SRC_MEM) && (rdE != 5'd0) &&
                       ((rdE == rs1D) || (rdE == rs2D));

    assign mem_fault = (r_state == FAULT);

    // Memory sequencer state and wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_waitCnt <= '0;
        end else begin
            r_state   <= w_stateNext;
            r_waitCnt <= w_waitCntNext;
        end
    end

    // Memory sequencer next state, request and stall
    always_comb begin
        w_stateNext   = r_state;
        w_waitCntNext = r_waitCnt;
        w_memStall    = 1'b0;
        w_memReq      = 1'b0;
        case (r_state)
            IDLE: begin
                w_memReq = mem_reqM;
                if (mem_reqM && !dmem_ready) begin
                    w_memStall    = 1'b1;
                    w_stateNext   = WAIT;
                    w_waitCntNext = c_CNT_ONE;
                end
            end
            WAIT: begin
                w_memReq = 1'b1;
                if (dmem_ready) begin
                    w_stateNext = IDLE;
                end else begin
                    w_memStall = 1'b1;
                    if (r_waitCnt == c_TIMEOUT_CNT) begin
                        w_stateNext = FAULT;
                    end else begin
                        w_waitCntNext = r_waitCnt + c_CNT_ONE;
                    end
                end
            end
            FAULT: begin
                // Request dropped; pipeline frozen until reset
                w_memStall = 1'b1;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Prioritised stall/flush outputs: reset, memory, branch, load-use
    always_comb begin
        dmem_req = w_memReq;
        stallF   = 1'b0;
        stallD   = 1'b0;
        stallE   = 1'b0;
        stallM   = 1'b0;
        flushD   = 1'b0;
        flushE   = 1'b0;
        flushW   = 1'b0;
        if (rst) begin
            dmem_req = 1'b0;
            flushD   = 1'b1;
            flushE   = 1'b1;
            flushW   = 1'b1;
        end else if (w_memStall) begin
            // Freeze everything up to M; W gets a bubble so nothing retires twice
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushW = 1'b1;
        end else if (pc_srcE) begin
            // D holds a wrong-path instruction, so a pending load-use is moot
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (w_lwStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stallCycles <= '0;
            r_flushCycles <= '0;
        end else begin
            if (stallF && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + 1'b1;
            end
            if (flushE && (r_flushCycles != '1)) begin
                r_flushCycles <= r_flushCycles + 1'b1;
            end
        end
    end

    assign stall_cycles = r_stallCycles;
    assign flush_cycles = r_flushCycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hazard_ctrl
//  Description : Scoreboard bench for hazard_ctrl with a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 4;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             reg_writeM, reg_writeW;
    logic [1:0]       result_srcE;
    logic             pc_srcE, mem_reqM, dmem_ready;
    logic             dmem_req;
    logic [1:0]       forwardAE, forwardBE;
    logic             stallF, stallD, stallE, stallM;
    logic             flushD, flushE, flushW;
    logic             mem_fault;
    logic [CNT_W-1:0] stall_cycles, flush_cycles;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
        .rdM(rdM), .rdW(rdW), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
        .result_srcE(result_srcE), .pc_srcE(pc_srcE), .mem_reqM(mem_reqM),
        .dmem_ready(dmem_ready), .dmem_req(dmem_req),
        .forwardAE(forwardAE), .forwardBE(forwardBE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
        .flushD(flushD), .flushE(flushE), .flushW(flushW),
        .mem_fault(mem_fault), .stall_cycles(stall_cycles), .flush_cycles(flush_cycles)
    );

    typedef struct {
        logic       rst;
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       reg_writeM, reg_writeW;
        logic [1:0] result_srcE;
        logic       pc_srcE, mem_reqM, dmem_ready;
    } stim_t;

    typedef struct {
        logic             req;
        logic [1:0]       fa, fb;
        logic             sF, sD, sE, sM, fD, fE, fW, fault;
        logic [CNT_W-1:0] sc, fc;
    } exp_t;

    exp_t expQ[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state: fault flag, age of the outstanding memory
    // access in cycles since its request (-1 = none), and counter values.
    bit mFault, nFault;
    int mAge, nAge, mStall, nStall, mFlush, nFlush;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, expv, $time);
        end
    endtask

    function automatic logic [1:0] fwdRef(input logic [4:0] rs, input stim_t s);
        if (s.reg_writeM && s.rdM != 0 && s.rdM == rs) return 2'b10;
        if (s.reg_writeW && s.rdW != 0 && s.rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic stim_t quiet();
        stim_t s;
        s.rst = 1'b0;
        s.rs1D = 5'd0; s.rs2D = 5'd0; s.rs1E = 5'd0; s.rs2E = 5'd0;
        s.rdE = 5'd0; s.rdM = 5'd0; s.rdW = 5'd0;
        s.reg_writeM = 1'b0; s.reg_writeW = 1'b0;
        s.result_srcE = 2'b00; s.pc_srcE = 1'b0;
        s.mem_reqM = 1'b0; s.dmem_ready = 1'b0;
        return s;
    endfunction

    // Drive one cycle of inputs and push the model's expected response
    task automatic apply(input stim_t s);
        exp_t e;
        bit   memStall, lw;
        int   age;
        rst = s.rst; rs1D = s.rs1D; rs2D = s.rs2D; rs1E = s.rs1E; rs2E = s.rs2E;
        rdE = s.rdE; rdM = s.rdM; rdW = s.rdW;
        reg_writeM = s.reg_writeM; reg_writeW = s.reg_writeW;
        result_srcE = s.result_srcE; pc_srcE = s.pc_srcE;
        mem_reqM = s.mem_reqM; dmem_ready = s.dmem_ready;

        e.fa = fwdRef(s.rs1E, s);
        e.fb = fwdRef(s.rs2E, s);
        e.fault = mFault;
        e.sc = mStall[CNT_W-1:0];
        e.fc = mFlush[CNT_W-1:0];
        e.req = 0; e.sF = 0; e.sD = 0; e.sE = 0; e.sM = 0;
        e.fD = 0; e.fE = 0; e.fW = 0;
        nFault = mFault; nAge = mAge; nStall = mStall; nFlush = mFlush;
        memStall = 0;

        if (s.rst) begin
            e.fD = 1; e.fE = 1; e.fW = 1;
            nFault = 0; nAge = -1; nStall = 0; nFlush = 0;
        end else begin
            age = (mAge >= 0) ? mAge : (s.mem_reqM ? 0 : -1);
            if (mFault) begin
                memStall = 1;
            end else if (age >= 0) begin
                e.req = 1;
                memStall = !s.dmem_ready;
                if (!memStall)           nAge = -1;
                else if (age >= TIMEOUT) begin nFault = 1; nAge = -1; end
                else                     nAge = age + 1;
            end
            lw = (s.result_srcE == 2'b01) && s.rdE != 0 &&
                 (s.rdE == s.rs1D || s.rdE == s.rs2D);
            if (memStall) begin
                e.sF = 1; e.sD = 1; e.sE = 1; e.sM = 1; e.fW = 1;
            end else if (s.pc_srcE) begin
                e.fD = 1; e.fE = 1;
            end else if (lw) begin
                e.sF = 1; e.sD = 1; e.fE = 1;
            end
            if (e.sF && nStall < SAT) nStall++;
            if (e.fE && nFlush < SAT) nFlush++;
        end
        expQ.push_back(e);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        mFault = nFault; mAge = nAge; mStall = nStall; mFlush = nFlush;
    endtask

    task automatic step(input stim_t s);
        apply(s);
        advance();
    endtask

    // Monitor: compare every presented cycle against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            cmp("dmem_req",     32'(dmem_req),     32'(e.req));
            cmp("forwardAE",    32'(forwardAE),    32'(e.fa));
            cmp("forwardBE",    32'(forwardBE),    32'(e.fb));
            cmp("stallF",       32'(stallF),       32'(e.sF));
            cmp("stallD",       32'(stallD),       32'(e.sD));
            cmp("stallE",       32'(stallE),       32'(e.sE));
            cmp("stallM",       32'(stallM),       32'(e.sM));
            cmp("flushD",       32'(flushD),       32'(e.fD));
            cmp("flushE",       32'(flushE),       32'(e.fE));
            cmp("flushW",       32'(flushW),       32'(e.fW));
            cmp("mem_fault",    32'(mem_fault),    32'(e.fault));
            cmp("stall_cycles", 32'(stall_cycles), 32'(e.sc));
            cmp("flush_cycles", 32'(flush_cycles), 32'(e.fc));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        stim_t s;
        bit    slow;

        s = quiet();
        s.rst = 1'b1;
        rst = 1'b1; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        reg_writeM = 0; reg_writeW = 0; result_srcE = 0; pc_srcE = 0;
        mem_reqM = 0; dmem_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        mFault = 0; mAge = -1; mStall = 0; mFlush = 0;

        // Reset-held outputs
        step(s);

        // Forwarding: M beats W, then W, then register file
        s = quiet();
        s.rs1E = 5; s.rdM = 5; s.reg_writeM = 1; s.rdW = 5; s.reg_writeW = 1;
        apply(s); #2; cmp("spot_fwdA_M", 32'(forwardAE), 32'(2'b10)); advance();
        s.rdM = 0;
        apply(s); #2; cmp("spot_fwdA_W", 32'(forwardAE), 32'(2'b01)); advance();
        s.rdW = 0;
        apply(s); #2; cmp("spot_fwdA_RF", 32'(forwardAE), 32'(2'b00)); advance();

        // Load-use for one cycle, then E advances
        s = quiet(); s.result_srcE = 2'b01; s.rdE = 7; s.rs2D = 7;
        step(s);
        s = quiet(); s.rs2D = 7;
        step(s);
        cmp("spot_stall_cnt_1", 32'(stall_cycles), 32'd1);

        // Branch overrides load-use
        s = quiet(); s.result_srcE = 2'b01; s.rdE = 7; s.rs1D = 7; s.pc_srcE = 1;
        apply(s); #2;
        cmp("spot_br_flushD", 32'(flushD), 32'd1);
        cmp("spot_br_stallF", 32'(stallF), 32'd0);
        advance();

        // Memory access with ready three cycles after the request, branch pending
        for (int i = 0; i < 4; i++) begin
            s = quiet(); s.mem_reqM = 1; s.pc_srcE = 1; s.dmem_ready = (i == 3);
            step(s);
        end
        // Back-to-back access completing immediately
        s = quiet(); s.mem_reqM = 1; s.dmem_ready = 1;
        step(s);

        // Timeout: ready never comes, later ready ignored
        for (int i = 0; i < 8; i++) begin
            s = quiet(); s.mem_reqM = 1;
            step(s);
        end
        cmp("spot_fault", 32'(mem_fault), 32'd1);
        s = quiet(); s.mem_reqM = 1; s.dmem_ready = 1;
        step(s);
        step(s);
        s = quiet(); s.rst = 1;
        step(s);
        cmp("spot_fault_clr", 32'(mem_fault), 32'd0);
        cmp("spot_cnt_clr", 32'(stall_cycles), 32'd0);
        step(quiet());

        // Counter saturation with a held load-use
        s = quiet(); s.result_srcE = 2'b01; s.rdE = 3; s.rs1D = 3;
        for (int i = 0; i < 20; i++) step(s);
        cmp("spot_stall_sat", 32'(stall_cycles), 32'(SAT));

        // Randomised traffic with occasional slow-memory phases and resets
        slow = 0;
        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) slow = ($urandom_range(0, 2) == 0);
            s.rst         = ($urandom_range(0, 59) == 0);
            s.rs1D        = 5'($urandom_range(0, 3));
            s.rs2D        = 5'($urandom_range(0, 3));
            s.rs1E        = 5'($urandom_range(0, 3));
            s.rs2E        = 5'($urandom_range(0, 3));
            s.rdE         = 5'($urandom_range(0, 3));
            s.rdM         = 5'($urandom_range(0, 3));
            s.rdW         = 5'($urandom_range(0, 3));
            s.reg_writeM  = 1'($urandom_range(0, 1));
            s.reg_writeW  = 1'($urandom_range(0, 1));
            s.result_srcE = 2'($urandom_range(0, 3));
            s.pc_srcE     = ($urandom_range(0, 4) == 0);
            s.mem_reqM    = ($urandom_range(0, 2) == 0);
            s.dmem_ready  = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            step(s);
        end

        for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
        if (expQ.size() > 0) cmp("scoreboard_drain", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
